memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 133 +++++++++++++
 tb/tb_memory_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one single-ported RAM between an instruction-fetch port and a data
// port. Data accesses normally win, but once STARVE_MAX data grants in a row
// have completed while a fetch was waiting, the next grant goes to the fetch.
//
// Ports
//   CLK, nRST             clock (rising edge) and asynchronous active-low reset
//   iREN, iaddr           instruction fetch request and word address
//   iload, iwait          fetched word and its completion strobe (active low)
//   dREN, dWEN            data read / write requests (write wins if both)
//   daddr, dstore         data address and write value
//   dload, dwait          data read value and completion strobe (active low)
//   ramREN, ramWEN        RAM read / write strobes
//   ramaddr, ramstore     RAM address and write data
//   ramload, ramready     RAM read data and access-complete flag
//   state_dbg             current FSM state (IDLE=0, IGRANT=1, DGRANT=2)
//   streak_dbg            consecutive data grants completed while a fetch waited
//
// Handshake: a requester holds its request (iREN, or dREN/dWEN) until the
// cycle in which its wait output is low. That is the only cycle in which the
// matching load output is valid. A requester that drops its request
// mid-grant abandons the access; the arbiter goes back to IDLE without
// signalling completion. Address, data and strobes are never latched, so they
// reach the RAM combinationally for the whole grant.
module memory_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic                               CLK,
   input  logic                               nRST,
   input  logic                               iREN,
   input  logic [31:0]                        iaddr,
   output logic [31:0]                        iload,
   output logic                               iwait,
   input  logic                               dREN,
   input  logic                               dWEN,
   input  logic [31:0]                        daddr,
   input  logic [31:0]                        dstore,
   output logic [31:0]                        dload,
   output logic                               dwait,
   output logic                               ramREN,
   output logic                               ramWEN,
   output logic [31:0]                        ramaddr,
   output logic [31:0]                        ramstore,
   input  logic [31:0]                        ramload,
   input  logic                               ramready,
   output logic [1:0]                         state_dbg,
   output logic [$clog2(STARVE_MAX+1)-1:0]    streak_dbg
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } state_t;

   state_t          state;
   logic [SW-1:0]   streak;
   logic            d_req;
   logic            i_done;
   logic            d_done;

   assign d_req  = dREN | dWEN;
   // A grant completes only if its requester still wants it when the RAM
   // answers; a dropped request is an abandon, not a completion.
   assign i_done = (state == IGRANT) & iREN  & ramready;
   assign d_done = (state == DGRANT) & d_req & ramready;

   assign state_dbg  = state;
   assign streak_dbg = streak;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         streak <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (d_req && !(iREN && streak == STARVE_LIMIT))
                  state <= DGRANT;
               else if (iREN)
                  state <= IGRANT;
            end
            // Both completion and abandon return to IDLE, which guarantees
            // at least one IDLE cycle between grants.
            IGRANT: if (!iREN || ramready) state <= IDLE;
            DGRANT: if (!d_req || ramready) state <= IDLE;
            default: state <= IDLE;
         endcase

         // The streak only counts data grants that actually made a fetch wait.
         if (!iREN || i_done)
            streak <= '0;
         else if (d_done && streak != STARVE_LIMIT)
            streak <= streak + SW'(1);
      end
   end

   always_comb begin
      iload    = '0;
      iwait    = 1'b1;
      dload    = '0;
      dwait    = 1'b1;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      case (state)
         IGRANT: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            if (i_done) begin
               iload = ramload;
               iwait = 1'b0;
            end
         end
         DGRANT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (d_done) begin
               dwait = 1'b0;
               if (!dWEN) dload = ramload;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter. Inputs are driven just after the falling
// edge and outputs are sampled 1 time unit later, so every check sees the
// state set by the previous rising edge plus the inputs of this cycle.
module tb_memory_arbiter;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dwait;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic        ramready;
   logic [1:0]  state_dbg;
   logic [2:0]  streak_dbg;

   int total = 0;
   int bad   = 0;

   localparam logic [1:0] S_IDLE = 2'd0, S_IGRANT = 2'd1, S_DGRANT = 2'd2;

   memory_arbiter #(.STARVE_MAX(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramready(ramready),
      .state_dbg(state_dbg), .streak_dbg(streak_dbg)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   task automatic clear_inputs();
      iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
      ramload = 0; ramready = 0;
   endtask

   task automatic test_reset();
      // Requests and a ready RAM are present; reset must still hold idle outputs.
      nRST = 0; iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h10;
      dstore = 32'h55; ramready = 1; ramload = 32'hA5A5A5A5;
      #2;
      total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg, S_IDLE); end
      total++; if (streak_dbg !== 3'd0) begin bad++; $display("FAIL rst_streak got=%0d exp=0", streak_dbg); end
      total++; if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin bad++; $display("FAIL rst_strobes got=%b exp=0011", {ramREN, ramWEN, iwait, dwait}); end
      total++; if ({iload, dload, ramaddr, ramstore} !== 128'd0) begin bad++; $display("FAIL rst_buses got=%h exp=0", {iload, dload, ramaddr, ramstore}); end
      @(negedge CLK); @(negedge CLK);
      total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL rst_hold got=%0d exp=%0d", state_dbg, S_IDLE); end
      clear_inputs();
      nRST = 1;
      #1;
      total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL rst_release got=%0d exp=%0d", state_dbg, S_IDLE); end
   endtask

   task automatic test_ifetch();
      @(negedge CLK);
      iREN = 1; iaddr = 32'h40; ramready = 1; ramload = 32'h8C220004;
      #1;
      total++; if (state_dbg !== S_IDLE || iwait !== 1'b1 || ramREN !== 1'b0) begin bad++; $display("FAIL if_c1 got=%0d/%b/%b exp=0/1/0", state_dbg, iwait, ramREN); end
      @(negedge CLK); #1;
      total++; if (state_dbg !== S_IGRANT) begin bad++; $display("FAIL if_c2_state got=%0d exp=%0d", state_dbg, S_IGRANT); end
      total++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin bad++; $display("FAIL if_c2_ram got=%b/%b/%h exp=1/0/00000040", ramREN, ramWEN, ramaddr); end
      total++; if (iwait !== 1'b0 || iload !== 32'h8C220004) begin bad++; $display("FAIL if_c2_load got=%b/%h exp=0/8c220004", iwait, iload); end
      total++; if (dwait !== 1'b1 || dload !== 32'd0) begin bad++; $display("FAIL if_c2_dside got=%b/%h exp=1/0", dwait, dload); end
      @(negedge CLK);
      iREN = 0; #1;
      total++; if (state_dbg !== S_IDLE || iwait !== 1'b1 || iload !== 32'd0) begin bad++; $display("FAIL if_c3 got=%0d/%b/%h exp=0/1/0", state_dbg, iwait, iload); end
      clear_inputs();
   endtask

   task automatic test_write_vs_fetch();
      @(negedge CLK);
      iREN = 1; iaddr = 32'h48; dREN = 1; dWEN = 1; daddr = 32'h100;
      dstore = 32'hDEADBEEF; ramready = 1; ramload = 32'h0BADF00D;
      #1;
      total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL wf_c1 got=%0d exp=%0d", state_dbg, S_IDLE); end
      @(negedge CLK); #1;
      total++; if (state_dbg !== S_DGRANT) begin bad++; $display("FAIL wf_grant got=%0d exp=%0d", state_dbg, S_DGRANT); end
      total++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEADBEEF || ramaddr !== 32'h100) begin bad++; $display("FAIL wf_ram got=%b/%b/%h/%h exp=1/0/deadbeef/00000100", ramWEN, ramREN, ramstore, ramaddr); end
      total++; if (dwait !== 1'b0 || dload !== 32'd0 || iwait !== 1'b1) begin bad++; $display("FAIL wf_done got=%b/%h/%b exp=0/0/1", dwait, dload, iwait); end
      @(negedge CLK);
      dREN = 0; dWEN = 0; #1;
      total++; if (state_dbg !== S_IDLE || streak_dbg !== 3'd1) begin bad++; $display("FAIL wf_idle got=%0d/%0d exp=0/1", state_dbg, streak_dbg); end
      @(negedge CLK); #1;
      total++; if (state_dbg !== S_IGRANT || iwait !== 1'b0 || iload !== 32'h0BADF00D || ramaddr !== 32'h48) begin bad++; $display("FAIL wf_fetch got=%0d/%b/%h/%h exp=1/0/0badf00d/00000048", state_dbg, iwait, iload, ramaddr); end
      @(negedge CLK);
      iREN = 0; #1;
      total++; if (state_dbg !== S_IDLE || streak_dbg !== 3'd0) begin bad++; $display("FAIL wf_after got=%0d/%0d exp=0/0", state_dbg, streak_dbg); end
      clear_inputs();
   endtask

   task automatic test_starve();
      @(negedge CLK);
      iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h300; ramready = 1;
      for (int g = 0; g < 5; g++) begin
         ramload = 32'h11110000 + g;
         #1;
         total++; if (state_dbg !== S_IDLE || streak_dbg !== 3'(g)) begin bad++; $display("FAIL st_idle%0d got=%0d/%0d exp=0/%0d", g, state_dbg, streak_dbg, g); end
         @(negedge CLK); #1;
         if (g < 4) begin
            total++; if (state_dbg !== S_DGRANT || dwait !== 1'b0 || dload !== 32'h11110000 + g || iwait !== 1'b1) begin bad++; $display("FAIL st_dgrant%0d got=%0d/%b/%h/%b exp=2/0/%h/1", g, state_dbg, dwait, dload, iwait, 32'h11110000 + g); end
         end else begin
            total++; if (state_dbg !== S_IGRANT || iwait !== 1'b0 || iload !== 32'h11110004 || dwait !== 1'b1) begin bad++; $display("FAIL st_igrant got=%0d/%b/%h/%b exp=1/0/11110004/1", state_dbg, iwait, iload, dwait); end
         end
         @(negedge CLK);
      end
      #1;
      total++; if (state_dbg !== S_IDLE || streak_dbg !== 3'd0) begin bad++; $display("FAIL st_clear got=%0d/%0d exp=0/0", state_dbg, streak_dbg); end
      clear_inputs();
   endtask

   task automatic test_wait_states();
      @(negedge CLK);
      dREN = 1; daddr = 32'h200; ramready = 0; ramload = 32'hFFFFFFFF;
      #1;
      total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL ws_c1 got=%0d exp=%0d", state_dbg, S_IDLE); end
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         if (c == 2) daddr = 32'h208;
         #1;
         total++; if (state_dbg !== S_DGRANT || dwait !== 1'b1 || dload !== 32'd0 || ramREN !== 1'b1) begin bad++; $display("FAIL ws_wait%0d got=%0d/%b/%h/%b exp=2/1/0/1", c, state_dbg, dwait, dload, ramREN); end
         total++; if (ramaddr !== ((c == 2) ? 32'h208 : 32'h200)) begin bad++; $display("FAIL ws_addr%0d got=%h exp=%h", c, ramaddr, (c == 2) ? 32'h208 : 32'h200); end
      end
      @(negedge CLK);
      daddr = 32'h200; ramready = 1; ramload = 32'h12345678; #1;
      total++; if (state_dbg !== S_DGRANT || dwait !== 1'b0 || dload !== 32'h12345678) begin bad++; $display("FAIL ws_done got=%0d/%b/%h exp=2/0/12345678", state_dbg, dwait, dload); end
      @(negedge CLK);
      dREN = 0; ramready = 0; #1;
      total++; if (state_dbg !== S_IDLE || dwait !== 1'b1 || dload !== 32'd0) begin bad++; $display("FAIL ws_idle got=%0d/%b/%h exp=0/1/0", state_dbg, dwait, dload); end
      clear_inputs();
   endtask

   task automatic test_drop();
      @(negedge CLK);
      iREN = 1; iaddr = 32'h90; ramready = 0; ramload = 32'h77777777; #1;
      total++; if (state_dbg !== S_IDLE || iwait !== 1'b1) begin bad++; $display("FAIL dr_c1 got=%0d/%b exp=0/1", state_dbg, iwait); end
      @(negedge CLK); #1;
      total++; if (state_dbg !== S_IGRANT || iwait !== 1'b1 || ramREN !== 1'b1) begin bad++; $display("FAIL dr_grant got=%0d/%b/%b exp=1/1/1", state_dbg, iwait, ramREN); end
      @(negedge CLK);
      iREN = 0; #1;
      total++; if (iwait !== 1'b1 || iload !== 32'd0) begin bad++; $display("FAIL dr_drop got=%b/%h exp=1/0", iwait, iload); end
      @(negedge CLK); #1;
      total++; if (state_dbg !== S_IDLE || iwait !== 1'b1 || ramREN !== 1'b0 || streak_dbg !== 3'd0) begin bad++; $display("FAIL dr_idle got=%0d/%b/%b/%0d exp=0/1/0/0", state_dbg, iwait, ramREN, streak_dbg); end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      // One completed write with a fetch waiting makes the streak nonzero.
      @(negedge CLK);
      iREN = 1; iaddr = 32'hA0; dWEN = 1; daddr = 32'h100; dstore = 32'hCAFEF00D; ramready = 1;
      @(negedge CLK);
      @(negedge CLK);
      ramready = 0; #1;
      total++; if (state_dbg !== S_IDLE || streak_dbg !== 3'd1) begin bad++; $display("FAIL rm_pre got=%0d/%0d exp=0/1", state_dbg, streak_dbg); end
      @(negedge CLK); #1;
      total++; if (state_dbg !== S_DGRANT || ramWEN !== 1'b1) begin bad++; $display("FAIL rm_grant got=%0d/%b exp=2/1", state_dbg, ramWEN); end
      #1 nRST = 0;
      #1;
      total++; if (ramWEN !== 1'b0 || dwait !== 1'b1 || ramaddr !== 32'd0 || state_dbg !== S_IDLE) begin bad++; $display("FAIL rm_async got=%b/%b/%h/%0d exp=0/1/0/0", ramWEN, dwait, ramaddr, state_dbg); end
      @(negedge CLK);
      clear_inputs();
      nRST = 1; #1;
      total++; if (streak_dbg !== 3'd0 || state_dbg !== S_IDLE) begin bad++; $display("FAIL rm_release got=%0d/%0d exp=0/0", streak_dbg, state_dbg); end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_ifetch();
      test_write_vs_fetch();
      test_starve();
      test_wait_states();
      test_drop();
      test_reset_mid();
      @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
